// File: rtl/dec_pkg.sv
// Shared decode definitions: ALU op codes, MIPS opcode/funct values, mux selects
// and the registered control bundle layout.
package dec_pkg;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_NOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REG    = 2'b11;

  localparam logic [1:0] GP_ALU = 2'b00;
  localparam logic [1:0] GP_MEM = 2'b01;
  localparam logic [1:0] GP_PC4 = 2'b10;
  localparam logic [1:0] GP_LUI = 2'b11;

  typedef struct packed {
    logic [3:0] alu_control;
    logic       alu_src;
    logic [1:0] pc_mux_sel;
    logic [1:0] gp_mux_sel;
    logic       branch;
    logic       jump;
    logic       branch_ne;
    logic       mem_to_reg;
    logic       mem_we;
    logic       reg_dst;
    logic       gp_we;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational MIPS decode: instruction word to control bundle, operand fields
// and the source-read flags used by the load-use check.
module decode_comb
  import dec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       instruction,
  output ctrl_t             ctrl,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        dst,
  output logic [4:0]        shamt,
  output logic [25:0]       jump_target,
  output logic [DATA_W-1:0] imm,
  output logic              reads_rs,
  output logic              reads_rt
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic        wr;
  logic        link;

  assign op          = instruction[31:26];
  assign fn          = instruction[5:0];
  assign rs          = instruction[25:21];
  assign rt          = instruction[20:16];
  assign rd          = instruction[15:11];
  assign shamt       = instruction[10:6];
  assign imm16       = instruction[15:0];
  assign jump_target = instruction[25:0];

  assign imm = is_zero_ext(op) ? DATA_W'(imm16) : DATA_W'($signed(imm16));

  always_comb begin
    ctrl     = '0;
    wr       = 1'b0;
    link     = 1'b0;
    reads_rs = 1'b1;
    reads_rt = 1'b0;
    dst      = 5'd0;

    case (op)
      OP_RTYPE: begin
        reads_rt = 1'b1;
        case (fn)
          FN_ADD: begin ctrl.alu_control = ALU_ADD; wr = 1'b1; end
          FN_SUB: begin ctrl.alu_control = ALU_SUB; wr = 1'b1; end
          FN_AND: begin ctrl.alu_control = ALU_AND; wr = 1'b1; end
          FN_OR:  begin ctrl.alu_control = ALU_OR;  wr = 1'b1; end
          FN_NOR: begin ctrl.alu_control = ALU_NOR; wr = 1'b1; end
          FN_SLT: begin ctrl.alu_control = ALU_SLT; wr = 1'b1; end
          FN_SLL: begin ctrl.alu_control = ALU_SLL; wr = 1'b1; end
          FN_SRL: begin ctrl.alu_control = ALU_SRL; wr = 1'b1; end
          FN_JR: begin
            ctrl.jump       = 1'b1;
            ctrl.pc_mux_sel = PC_REG;
          end
          default: ctrl.illegal = 1'b1;
        endcase
        ctrl.reg_dst = wr;
      end
      OP_ADDI: begin ctrl.alu_control = ALU_ADD; ctrl.alu_src = 1'b1; wr = 1'b1; end
      OP_SLTI: begin ctrl.alu_control = ALU_SLT; ctrl.alu_src = 1'b1; wr = 1'b1; end
      OP_ANDI: begin ctrl.alu_control = ALU_AND; ctrl.alu_src = 1'b1; wr = 1'b1; end
      OP_ORI:  begin ctrl.alu_control = ALU_OR;  ctrl.alu_src = 1'b1; wr = 1'b1; end
      OP_LUI: begin
        ctrl.alu_src    = 1'b1;
        ctrl.gp_mux_sel = GP_LUI;
        wr              = 1'b1;
        reads_rs        = 1'b0;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.gp_mux_sel = GP_MEM;
        wr              = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src = 1'b1;
        ctrl.mem_we  = 1'b1;
        reads_rt     = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.alu_control = ALU_SUB;
        ctrl.branch      = 1'b1;
        ctrl.branch_ne   = (op == OP_BNE);
        ctrl.pc_mux_sel  = PC_BRANCH;
        reads_rt         = 1'b1;
      end
      OP_J: begin
        ctrl.jump       = 1'b1;
        ctrl.pc_mux_sel = PC_JUMP;
        reads_rs        = 1'b0;
      end
      OP_JAL: begin
        ctrl.jump       = 1'b1;
        ctrl.pc_mux_sel = PC_JUMP;
        ctrl.gp_mux_sel = GP_PC4;
        wr              = 1'b1;
        link            = 1'b1;
        reads_rs        = 1'b0;
      end
      default: ctrl.illegal = 1'b1;
    endcase

    // Writes to $0 are architecturally dropped, so never assert the enable for them.
    dst        = link ? 5'd31 : (ctrl.reg_dst ? rd : rt);
    ctrl.gp_we = wr && (dst != 5'd0);
  end

endmodule

// File: rtl/pipelined_instruction_decoder.sv
// Registered decode stage between IF and EX: valid/ready handshake, one-entry
// output register, load-use bubble insertion and flush.
module pipelined_instruction_decoder
  import dec_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit HAZARD_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic [DATA_W-1:0]     pc_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            alu_control,
  output logic                  alu_src,
  output logic [1:0]            pc_mux_sel,
  output logic [1:0]            gp_mux_sel,
  output logic                  branch,
  output logic                  jump,
  output logic                  branch_ne,
  output logic                  mem_to_reg,
  output logic                  mem_we,
  output logic                  reg_dst,
  output logic                  gp_we,
  output logic [REG_ADDR_W-1:0] rs,
  output logic [REG_ADDR_W-1:0] rt,
  output logic [REG_ADDR_W-1:0] gp_dst,
  output logic [DATA_W-1:0]     imm,
  output logic [4:0]            shamt,
  output logic [25:0]           jump_target,
  output logic [DATA_W-1:0]     pc_out,
  output logic                  illegal
);

  ctrl_t             d_ctrl;
  logic [4:0]        d_rs, d_rt, d_dst, d_shamt;
  logic [25:0]       d_jt;
  logic [DATA_W-1:0] d_imm;
  logic              d_reads_rs, d_reads_rt;

  decode_comb #(.DATA_W(DATA_W)) u_decode (
    .instruction (instruction),
    .ctrl        (d_ctrl),
    .rs          (d_rs),
    .rt          (d_rt),
    .dst         (d_dst),
    .shamt       (d_shamt),
    .jump_target (d_jt),
    .imm         (d_imm),
    .reads_rs    (d_reads_rs),
    .reads_rt    (d_reads_rt)
  );

  ctrl_t             ctrl_q;
  logic [4:0]        rs_q, rt_q, dst_q, shamt_q;
  logic [25:0]       jt_q;
  logic [DATA_W-1:0] imm_q, pc_q;
  logic              track_valid;
  logic [4:0]        track_dst;
  logic              hit;
  logic              stall;
  logic              accept;

  assign hit = (d_reads_rs && (d_rs == track_dst)) || (d_reads_rt && (d_rt == track_dst));
  assign stall  = HAZARD_EN && in_valid && track_valid && (track_dst != 5'd0) && hit;
  assign in_ready = !flush && (!out_valid || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      dst_q     <= '0;
      shamt_q   <= '0;
      jt_q      <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      ctrl_q    <= d_ctrl;
      rs_q      <= d_rs;
      rt_q      <= d_rt;
      dst_q     <= d_dst;
      shamt_q   <= d_shamt;
      jt_q      <= d_jt;
      imm_q     <= d_imm;
      pc_q      <= pc_in;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A load handed to EX this cycle can only collide with the instruction offered next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      track_valid <= 1'b0;
      track_dst   <= '0;
    end else if (flush) begin
      track_valid <= 1'b0;
    end else begin
      track_valid <= out_valid && out_ready && ctrl_q.mem_to_reg && ctrl_q.gp_we;
      track_dst   <= dst_q;
    end
  end

  assign alu_control = ctrl_q.alu_control;
  assign alu_src     = ctrl_q.alu_src;
  assign pc_mux_sel  = ctrl_q.pc_mux_sel;
  assign gp_mux_sel  = ctrl_q.gp_mux_sel;
  assign branch      = ctrl_q.branch;
  assign jump        = ctrl_q.jump;
  assign branch_ne   = ctrl_q.branch_ne;
  assign mem_to_reg  = ctrl_q.mem_to_reg;
  assign mem_we      = ctrl_q.mem_we;
  assign reg_dst     = ctrl_q.reg_dst;
  assign gp_we       = ctrl_q.gp_we;
  assign illegal     = ctrl_q.illegal;
  assign rs          = REG_ADDR_W'(rs_q);
  assign rt          = REG_ADDR_W'(rt_q);
  assign gp_dst      = REG_ADDR_W'(dst_q);
  assign imm         = imm_q;
  assign shamt       = shamt_q;
  assign jump_target = jt_q;
  assign pc_out      = pc_q;

endmodule
